// File: rtl/cam_update_ctrl_pkg.sv
// Shared types for the CAM update controller: request opcodes and FSM states.
package cam_update_ctrl_pkg;

  localparam int OP_WIDTH = 2;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_FILL      = 2'd0,
    OP_INVAL     = 2'd1,
    OP_INVAL_ALL = 2'd2,
    OP_RESERVED  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_WRITE = 2'd2,
    ST_SWEEP = 2'd3
  } state_e;

endpackage

// File: rtl/cam_free_sel.sv
// Finds the lowest-numbered free CAM slot from the shadow valid vector.
module cam_free_sel #(
  parameter int NUM_ENTRIES = 2,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] valid_vec,
  output logic                   any_free,
  output logic [INDEX_WIDTH-1:0] free_idx
);

  logic [NUM_ENTRIES-1:0] free_vec;
  logic [NUM_ENTRIES-1:0] free_oh;

  function automatic logic [INDEX_WIDTH-1:0] oh_to_idx(input logic [NUM_ENTRIES-1:0] oh);
    logic [INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (oh[i]) idx = idx | INDEX_WIDTH'(i);
    end
    return idx;
  endfunction

  assign free_vec = ~valid_vec;
  // x & -x keeps only the lowest set bit
  assign free_oh  = free_vec & (~free_vec + 1'b1);
  assign any_free = |free_vec;
  assign free_idx = oh_to_idx(free_oh);

endmodule

// File: rtl/cam_update_ctrl.sv
// Update-side controller for a CAM: probes before writing so keys are never
// duplicated, and picks victims first-free, then round-robin.
module cam_update_ctrl
  import cam_update_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES = 2,
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  output logic                   resp_valid,
  output logic [INDEX_WIDTH-1:0] resp_idx,
  output logic                   resp_hit,
  output logic                   resp_evict,
  output logic [KEY_WIDTH-1:0]   probe_key,
  input  logic                   probe_hit,
  input  logic [INDEX_WIDTH-1:0] probe_idx,
  output logic                   update_en,
  output logic [KEY_WIDTH-1:0]   update_key,
  output logic [INDEX_WIDTH-1:0] update_idx,
  output logic                   update_valid
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_ENTRIES - 1);

  state_e                   state_q, state_d;
  op_e                      op_q, op_d;
  logic [KEY_WIDTH-1:0]     key_q, key_d;
  logic [INDEX_WIDTH-1:0]   target_q, target_d;
  logic                     wval_q, wval_d;
  logic                     hit_q, hit_d;
  logic                     evict_q, evict_d;
  logic [INDEX_WIDTH-1:0]   rr_q, rr_d;
  logic [INDEX_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_ENTRIES-1:0]   shadow_q, shadow_d;

  logic                     any_free;
  logic [INDEX_WIDTH-1:0]   free_idx;

  cam_free_sel #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_free_sel (
    .valid_vec (shadow_q),
    .any_free  (any_free),
    .free_idx  (free_idx)
  );

  // The CAM shares this reset, so clearing shadow_q keeps the mirror exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_FILL;
      key_q    <= '0;
      target_q <= '0;
      wval_q   <= 1'b0;
      hit_q    <= 1'b0;
      evict_q  <= 1'b0;
      rr_q     <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      target_q <= target_d;
      wval_q   <= wval_d;
      hit_q    <= hit_d;
      evict_q  <= evict_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign probe_key = key_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    key_d        = key_q;
    target_d     = target_q;
    wval_d       = wval_q;
    hit_d        = hit_q;
    evict_d      = evict_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_idx     = '0;
    resp_hit     = 1'b0;
    resp_evict   = 1'b0;
    update_en    = 1'b0;
    update_key   = key_q;
    update_idx   = '0;
    update_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op_e'(req_op);
          key_d   = req_key;
          cnt_d   = '0;
          state_d = (op_e'(req_op) == OP_INVAL_ALL) ? ST_SWEEP : ST_PROBE;
        end
      end

      ST_PROBE: begin
        hit_d   = probe_hit;
        evict_d = 1'b0;
        case (op_q)
          OP_FILL: begin
            wval_d  = 1'b1;
            state_d = ST_WRITE;
            if (probe_hit) begin
              target_d = probe_idx;
            end else if (any_free) begin
              target_d = free_idx;
            end else begin
              target_d = rr_q;
              evict_d  = 1'b1;
              rr_d     = (rr_q == LAST_IDX) ? '0 : rr_q + 1'b1;
            end
          end
          OP_INVAL: begin
            if (probe_hit) begin
              wval_d   = 1'b0;
              target_d = probe_idx;
              state_d  = ST_WRITE;
            end else begin
              resp_valid = 1'b1;
              resp_idx   = probe_idx;
              state_d    = ST_IDLE;
            end
          end
          default: begin
            // Reserved ops complete like an invalidate miss.
            resp_valid = 1'b1;
            resp_idx   = probe_idx;
            state_d    = ST_IDLE;
          end
        endcase
      end

      ST_WRITE: begin
        update_en          = 1'b1;
        update_idx         = target_q;
        update_valid       = wval_q;
        resp_valid         = 1'b1;
        resp_idx           = target_q;
        resp_hit           = hit_q;
        resp_evict         = evict_q;
        shadow_d[target_q] = wval_q;
        state_d            = ST_IDLE;
      end

      ST_SWEEP: begin
        update_en       = 1'b1;
        update_idx      = cnt_q;
        update_key      = '0;
        shadow_d[cnt_q] = 1'b0;
        if (cnt_q == LAST_IDX) begin
          resp_valid = 1'b1;
          resp_idx   = cnt_q;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cam_update_ctrl.sv
// Bench for cam_update_ctrl with a behavioural 4-entry CAM on the probe/update ports.
module tb_cam_update_ctrl;

  localparam int N  = 4;
  localparam int KW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [KW-1:0] req_key;
  logic          resp_valid;
  logic [IW-1:0] resp_idx;
  logic          resp_hit;
  logic          resp_evict;
  logic [KW-1:0] probe_key;
  logic          probe_hit;
  logic [IW-1:0] probe_idx;
  logic          update_en;
  logic [KW-1:0] update_key;
  logic [IW-1:0] update_idx;
  logic          update_valid;

  cam_update_ctrl #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .resp_valid(resp_valid), .resp_idx(resp_idx), .resp_hit(resp_hit), .resp_evict(resp_evict),
    .probe_key(probe_key), .probe_hit(probe_hit), .probe_idx(probe_idx),
    .update_en(update_en), .update_key(update_key), .update_idx(update_idx),
    .update_valid(update_valid)
  );

  always #5 clk = ~clk;

  // Attached CAM: combinational lookup (lowest matching slot, 0 on miss), registered update.
  logic [KW-1:0] cam_key [N];
  logic          cam_vld [N];
  int            dup_cnt = 0;

  always_comb begin
    probe_hit = 1'b0;
    probe_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cam_vld[i] && cam_key[i] == probe_key) begin
        probe_hit = 1'b1;
        probe_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        cam_key[i] <= '0;
        cam_vld[i] <= 1'b0;
      end
    end else if (update_en) begin
      cam_key[update_idx] <= update_key;
      cam_vld[update_idx] <= update_valid;
    end
  end

  function automatic bit cam_dup(input logic [KW-1:0] k, input logic [IW-1:0] at);
    bit d;
    d = 1'b0;
    for (int i = 0; i < N; i++)
      if (cam_vld[i] && cam_key[i] == k && IW'(i) != at) d = 1'b1;
    return d;
  endfunction

  always @(posedge clk) begin
    if (!reset && update_en && update_valid && cam_dup(update_key, update_idx))
      dup_cnt <= dup_cnt + 1;
  end

  function automatic bit cam_has(input logic [KW-1:0] k);
    bit h;
    h = 1'b0;
    for (int i = 0; i < N; i++)
      if (cam_vld[i] && cam_key[i] == k) h = 1'b1;
    return h;
  endfunction

  // Reference model: contents as plain arrays plus a round-robin victim pointer.
  logic [KW-1:0] m_key [N];
  bit            m_vld [N];
  int            m_rr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    m_rr = 0;
  endtask

  function automatic bit m_has(input logic [KW-1:0] k);
    bit h;
    h = 1'b0;
    for (int i = 0; i < N; i++)
      if (m_vld[i] && m_key[i] == k) h = 1'b1;
    return h;
  endfunction

  // Issue one request from IDLE, predict its outcome, and check it cycle by cycle.
  task automatic send(input logic [1:0] op, input logic [KW-1:0] key, input string tag);
    int  hit_i, free_i, e_idx, e_resp_lat, e_ready_lat, e_nupd;
    bit  e_hit, e_evict, e_uval;
    int  got_resp_lat, got_ready_lat, nresp, nupd;

    hit_i  = -1;
    free_i = -1;
    for (int i = 0; i < N; i++) begin
      if (hit_i < 0 && m_vld[i] && m_key[i] == key) hit_i = i;
      if (free_i < 0 && !m_vld[i]) free_i = i;
    end
    e_hit = 1'b0; e_evict = 1'b0; e_uval = 1'b0; e_idx = 0;
    case (op)
      2'd0: begin
        if (hit_i >= 0) begin
          e_idx = hit_i; e_hit = 1'b1;
        end else if (free_i >= 0) begin
          e_idx = free_i;
        end else begin
          e_idx = m_rr; e_evict = 1'b1; m_rr = (m_rr + 1) % N;
        end
        m_key[e_idx] = key; m_vld[e_idx] = 1'b1;
        e_uval = 1'b1; e_resp_lat = 2; e_ready_lat = 3; e_nupd = 1;
      end
      2'd1: begin
        if (hit_i >= 0) begin
          e_idx = hit_i; e_hit = 1'b1; m_vld[hit_i] = 1'b0;
          e_resp_lat = 2; e_ready_lat = 3; e_nupd = 1;
        end else begin
          e_resp_lat = 1; e_ready_lat = 2; e_nupd = 0;
        end
      end
      2'd2: begin
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        e_idx = N - 1; e_resp_lat = N; e_ready_lat = N + 1; e_nupd = N;
      end
      default: begin
        e_idx = (hit_i >= 0) ? hit_i : 0;
        e_resp_lat = 1; e_ready_lat = 2; e_nupd = 0;
      end
    endcase

    @(negedge clk);
    chk({tag, ".ready_at_issue"}, req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_key   = $urandom;

    got_resp_lat = -1; got_ready_lat = -1; nresp = 0; nupd = 0;
    for (int k = 1; k <= 12; k++) begin
      if (update_en) begin
        nupd++;
        if (op == 2'd2) begin
          chk({tag, ".sweep_idx"}, update_idx, k - 1);
          chk({tag, ".sweep_valid"}, update_valid, 0);
          chk({tag, ".sweep_key"}, update_key, 0);
        end else begin
          chk({tag, ".upd_cycle"}, k, 2);
          chk({tag, ".upd_idx"}, update_idx, e_idx);
          chk({tag, ".upd_valid"}, update_valid, e_uval);
          chk({tag, ".upd_key"}, update_key, key);
        end
      end
      if (resp_valid) begin
        nresp++;
        got_resp_lat = k;
        chk({tag, ".resp_idx"}, resp_idx, e_idx);
        chk({tag, ".resp_hit"}, resp_hit, e_hit);
        chk({tag, ".resp_evict"}, resp_evict, e_evict);
      end
      if (req_ready) begin
        got_ready_lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, ".resp_count"}, nresp, 1);
    chk({tag, ".resp_lat"}, got_resp_lat, e_resp_lat);
    chk({tag, ".ready_lat"}, got_ready_lat, e_ready_lat);
    chk({tag, ".upd_count"}, nupd, e_nupd);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_key   = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", req_ready, 1);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_idx", resp_idx, 0);
    chk("rst.resp_hit", resp_hit, 0);
    chk("rst.resp_evict", resp_evict, 0);
    chk("rst.update_en", update_en, 0);
    chk("rst.update_key", update_key, 0);
    chk("rst.update_idx", update_idx, 0);
    chk("rst.update_valid", update_valid, 0);
    chk("rst.probe_key", probe_key, 0);
    @(negedge clk);
    reset = 1'b0;

    send(2'd0, 32'hA, "fill_a");
    send(2'd0, 32'hB, "fill_b");
    send(2'd0, 32'hC, "fill_c");
    send(2'd0, 32'hD, "fill_d");
    chk("full.has_d", cam_has(32'hD), 1);
    send(2'd0, 32'hE, "fill_e_evict");
    send(2'd0, 32'hF, "fill_f_evict");
    chk("evict.a_gone", cam_has(32'hA), 0);
    chk("evict.e_present", cam_has(32'hE), 1);
    send(2'd0, 32'hC, "fill_c_again");
    send(2'd3, 32'hC, "reserved_op");
    send(2'd2, 32'h0, "inval_all");
    chk("sweep.c_gone", cam_has(32'hC), 0);
    send(2'd0, 32'h5, "fill_5");
    send(2'd0, 32'hB, "fill_b2");
    send(2'd1, 32'hB, "inval_b");
    send(2'd1, 32'hB, "inval_b_miss");
    chk("inval.b_gone", cam_has(32'hB), 0);

    // Reset during the second sweep cycle drops the remaining updates.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rstsweep.upd_before", update_en, 1);
    chk("rstsweep.idx_before", update_idx, 1);
    reset = 1'b1;
    #1;
    chk("rstsweep.update_en", update_en, 0);
    chk("rstsweep.req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    send(2'd0, 32'h77, "fill_after_reset");

    for (int t = 0; t < 80; t++) begin
      int       r;
      logic [1:0] op;
      r  = $urandom_range(0, 99);
      op = (r < 60) ? 2'd0 : (r < 85) ? 2'd1 : (r < 92) ? 2'd3 : 2'd2;
      send(op, 32'($urandom_range(1, 7)), "rand");
    end
    for (int i = 1; i <= 7; i++)
      chk("final.contents", cam_has(32'(i)), m_has(32'(i)));
    chk("no_duplicate_install", dup_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cam_update_ctrl.md
# cam_update_ctrl

Update-side controller for the `cam` lookup block. It owns the CAM's update port and accepts fill, invalidate and invalidate-all requests over a valid/ready handshake. It probes the CAM first so that a key is never installed twice, and it picks victim slots using a first-free, then round-robin, policy. It sits between a miss/flush source (TLB refill, tag-directory manager) and a `cam` instance with matching parameters.

## Interface
Parameters:
- NUM_ENTRIES, 2, number of CAM slots; must match the attached `cam`.
- KEY_WIDTH, 32, key width.
- INDEX_WIDTH, $clog2(NUM_ENTRIES), slot index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_op  in  2  0=FILL, 1=INVAL, 2=INVAL_ALL, 3=reserved.
- req_key  in  KEY_WIDTH  key for FILL/INVAL; ignored for INVAL_ALL.
- resp_valid  out  1  one-cycle completion pulse.
- resp_idx  out  INDEX_WIDTH  slot written; probe index on INVAL miss.
- resp_hit  out  1  key was already present at probe.
- resp_evict  out  1  FILL overwrote a valid entry holding a different key.
- probe_key  out  KEY_WIDTH  drives cam lookup_key.
- probe_hit  in  1  from cam lookup_hit (combinational).
- probe_idx  in  INDEX_WIDTH  from cam lookup_idx.
- update_en, update_key, update_idx, update_valid  out  1/KEY_WIDTH/INDEX_WIDTH/1  drive the cam update port.

Clock is clk. Reset is `reset`: asynchronous, active-high.

## Operation
- States: IDLE, PROBE, WRITE, SWEEP.
- IDLE: req_ready=1. On req_valid, latch op and key.
  - INVAL_ALL goes to SWEEP with sweep counter 0.
  - All other ops go to PROBE.
- PROBE: probe_key=latched key. Sample probe_hit and probe_idx.
  - FILL, hit: target=probe_idx, resp_hit=1, resp_evict=0.
  - FILL, miss, any shadow-valid bit clear: target=lowest clear index, resp_evict=0.
  - FILL, miss, all shadow-valid bits set: target=rr_ptr, resp_evict=1, rr_ptr advances (wraps NUM_ENTRIES-1 to 0).
  - FILL always goes to WRITE with valid=1.
  - INVAL, hit: WRITE with valid=0 at probe_idx.
  - INVAL, miss: resp_valid=1 and resp_hit=0 in this cycle, no update, go to IDLE.
  - Reserved op: handled like INVAL miss.
- WRITE: update_en=1 for exactly one cycle with the latched key, target index and valid flag. resp_valid=1 in the same cycle. Shadow valid[target] takes the valid flag. Go to IDLE.
- SWEEP: update_en=1, update_valid=0, update_idx=counter, every cycle for NUM_ENTRIES cycles.
  - Shadow valid bits are cleared as swept.
  - resp_valid=1 on the final cycle, with resp_idx=NUM_ENTRIES-1.
  - Go to IDLE. rr_ptr is not modified.
- Shadow valid vector mirrors the CAM's entry_valid. It is written only by this block.
- update_key is don't-care when update_valid=0; drive the latched key (0 in SWEEP).
- Outputs are decoded from registered state only. No combinational path exists from req_* to update_*.
- Reset values: state=IDLE, req_ready=1, resp_valid/resp_hit/resp_evict=0, resp_idx=0, update_en=0, update_key=0, update_idx=0, update_valid=0, probe_key=0, shadow valid=0, rr_ptr=0, sweep counter=0.

## Timing
- FILL/INVAL-hit accepted at cycle N: PROBE at N+1, update_en and resp_valid at N+2, CAM hit visible at N+3, req_ready high again at N+3.
- INVAL miss or reserved op: resp_valid at N+1, req_ready high again at N+2.
- INVAL_ALL accepted at N: update_en during N+1 .. N+NUM_ENTRIES, req_ready high again at N+NUM_ENTRIES+1.
- req_ready is low in PROBE, WRITE and SWEEP. A held req_valid waits, with no loss or duplication.
- probe_hit/probe_idx are sampled only in PROBE. This is safe because the CAM is not written in PROBE.
- Async reset mid-operation: immediate return to IDLE; any pending update is dropped. The attached `cam` shares the reset, so the shadow state stays consistent.

## Structure
- Shared package: op enum (FILL, INVAL, INVAL_ALL, RESERVED) and state enum.
- One sub-module, `cam_free_sel`:
  - Isolates the lowest clear shadow-valid bit as one-hot, then converts it with `oh_to_idx`.
  - Outputs `any_free` and `free_idx`.
- Top level holds the FSM, rr_ptr, sweep counter, latches and shadow vector. Target size is about 150–250 lines.

## Test plan
All scenarios use NUM_ENTRIES=4 with a real `cam` attached.
- Fills of keys 0xA, 0xB, 0xC, 0xD into an empty CAM → resp_idx 0,1,2,3; resp_hit=0 and resp_evict=0 on each; update_en asserted 2 cycles after each accept.
- Fill of 0xE with the CAM full → resp_idx=0, resp_evict=1. Then fill 0xF → resp_idx=1 (rr_ptr advanced). Lookup of 0xA then misses.
- Fill of existing key 0xC → resp_hit=1, resp_idx=2, resp_evict=0; no duplicate-entry abort.
- INVAL 0xB → WRITE at idx 1 with update_valid=0, resp_hit=1. A second INVAL 0xB → resp_hit=0, no update_en, resp_valid 1 cycle after accept.
- INVAL_ALL → update_en for 4 consecutive cycles, idx 0..3. A following FILL 0x5 → resp_idx=0.
- Reset asserted in the 2nd SWEEP cycle → update_en=0 and req_ready=1 immediately. A following fill → resp_idx=0.
